binary_to_gray_conv: RTL and testbench
======================================

// Module: binary_to_gray_conv
// PURPOSE
//   Registered binary-to-Gray-code converter for counter/pointer encoding, e.g. FIFO
//     pointers crossing clock domains.
//   Encodes each valid binary word as Gray code (gray = bin ^ (bin >> 1)).
//   The result is presented one clock later with a matching valid strobe.
// PARAMETERS
//   WIDTH   4   bit width of binary input and Gray output (legal range 2..32)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      reset, asynchronous and active-low
//   in_valid   in   1      binary input qualifier
//   binary     in   WIDTH  binary value to encode
//   gray       out  WIDTH  registered Gray-code result
//   out_valid  out  1      high for one cycle per accepted input
//   bin_chk    out  WIDTH  decoded-back binary (GRAY_CHECK_EN only)
//   chk_err    out  1      round-trip mismatch flag (GRAY_CHECK_EN only)
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous assert): gray=0, out_valid=0, bin_chk=0, chk_err=0
//     immediately, without waiting for clk.
//   - Reset release is synchronous to clk. The first accept can occur on the first
//     rising edge after rst_n=1.
//   - Encoding: gray[WIDTH-1] = binary[WIDTH-1];
//     gray[i] = binary[i+1] ^ binary[i] for i = WIDTH-2..0.
//   - Latency: 1 cycle. binary is sampled on an edge where in_valid=1; gray and
//     out_valid=1 appear after that edge.
//   - Idle edge (in_valid=0): out_valid goes 0, gray holds its last value.
//   - Back-to-back: in_valid held high gives one result per cycle with no bubbles.
//     No backpressure; there is no ready signal.
//   - Adjacent binary values (n, n+1 mod 2^WIDTH) yield Gray words differing in exactly
//     1 bit. This includes the wrap from all-ones to zero (4'b1111 -> 4'b0000 gives
//     Gray 1000 -> 0000).
//   - X/Z on binary while in_valid=0 must not propagate to gray.
//   - Reset mid-stream: pending result discarded, outputs forced to reset values.
//   - Purely datapath; no state machine beyond the output registers.
// CONFIGURATION
//   GRAY_CHECK_EN defined:
//     - Adds a Gray-to-binary decoder on the registered gray:
//       bin_chk[WIDTH-1] = gray[WIDTH-1];
//       bin_chk[i] = bin_chk[i+1] ^ gray[i].
//     - A registered copy of the accepted binary is kept.
//     - chk_err is registered; it is set the cycle after out_valid if bin_chk differs
//       from that copy.
//     - chk_err is sticky until reset.
//   GRAY_CHECK_EN undefined:
//     - bin_chk and chk_err are not present as ports.
//     - No checker logic is synthesized.
// TESTING
//   1. Reset: assert rst_n=0 mid-cycle -> gray=0, out_valid=0 at once, before the next
//      clk edge.
//   2. Sweep WIDTH=4, 0..15 with in_valid=1, one per cycle. Each cycle later, gray
//      must be:
//      0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000
//   3. Single-bit step: every consecutive pair in sweep 2, plus wrap 1111->0000, has
//      Hamming distance 1.
//   4. Valid gating: binary=4'b1010 with in_valid=0 -> gray unchanged, out_valid=0.
//      Then in_valid=1 -> gray=1111 and out_valid=1 for exactly one cycle.
//   5. Reset mid-stream: stream 5,6,7 and pull rst_n low after 6 is accepted ->
//      gray=0, out_valid=0. No 0101 (the encoding of 6) or 0100 (the encoding of 7)
//      appears after release.
//   6. GRAY_CHECK_EN: full sweep -> bin_chk equals input one cycle later, chk_err stays 0.
//      Force a corrupted gray bit -> chk_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/binary_to_gray_conv.sv
// binary_to_gray_conv: registered binary-to-Gray encoder with a one-cycle valid strobe.
// Define GRAY_CHECK_EN to add a Gray-to-binary round-trip checker with a sticky error flag.
module binary_to_gray_conv #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
`ifdef GRAY_CHECK_EN
  output logic [WIDTH-1:0] bin_chk,
  output logic             chk_err,
`endif
  output logic             out_valid
);
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             vld_q;
  // The enable keeps undriven binary values out of gray while idle.
  always_comb gray_d = in_valid ? (binary ^ (binary >> 1)) : gray_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gray_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      gray_q <= gray_d;
      vld_q  <= in_valid;
    end
  assign gray      = gray_q;
  assign out_valid = vld_q;
`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] bin_q, bin_d, dec;
  logic             err_q, err_d;
  // Each decoded bit is the XOR of all Gray bits at or above it.
  for (genvar g = 0; g < WIDTH; g++) begin : g_dec
    assign dec[g] = ^gray_q[WIDTH-1:g];
  end
  always_comb begin
    bin_d = in_valid ? binary : bin_q;
    err_d = err_q | (vld_q && (dec != bin_q));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      err_q <= err_d;
    end
  assign bin_chk = dec;
  assign chk_err = err_q;
`endif
endmodule

// File: tb/tb_binary_to_gray_conv.sv
// tb_binary_to_gray_conv: directed vectors plus a cycle-by-cycle reference model check.
module tb_binary_to_gray_conv;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [W-1:0] binary = '0, gray;
  logic out_valid;
`ifdef GRAY_CHECK_EN
  logic [W-1:0] bin_chk;
  logic chk_err;
`endif
  int checks = 0, fails = 0;
  bit forcing = 1'b0;
  logic [W-1:0] tbl [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                             4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
  binary_to_gray_conv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .binary(binary), .gray(gray),
`ifdef GRAY_CHECK_EN
    .bin_chk(bin_chk), .chk_err(chk_err),
`endif
    .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  // Reference model: last accepted word and its Gray code, valid one cycle later.
  logic [W-1:0] m_gray, m_bin;
  logic m_vld;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_gray <= '0; m_bin <= '0; m_vld <= 1'b0;
    end else begin
      m_vld <= in_valid;
      if (in_valid) begin
        m_gray <= binary ^ (binary >> 1);
        m_bin  <= binary;
      end
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    check("model_valid", out_valid, m_vld);
    if (!forcing) check("model_gray", gray, m_gray);
`ifdef GRAY_CHECK_EN
    if (!forcing) begin
      check("model_bin_chk", bin_chk, m_bin);
      check("model_chk_err", chk_err, 0);
    end
`endif
  end
  task automatic step(input logic v, input logic [W-1:0] b);
    in_valid = v;
    binary = b;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [W-1:0] prev;
    #2;
    check("reset_gray", gray, 0);
    check("reset_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    prev = '0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, W'(i));
      check($sformatf("sweep_gray_%0d", i), gray, tbl[i]);
      check("sweep_valid", out_valid, 1);
      if (i > 0) check($sformatf("hamming_%0d", i), $countones(gray ^ prev), 1);
      prev = gray;
    end
    step(1'b1, 4'b0000);
    check("wrap_gray", gray, 4'b0000);
    check("wrap_hamming", $countones(gray ^ prev), 1);
    step(1'b0, 4'b1010);
    check("gate_hold_gray", gray, 4'b0000);
    check("gate_idle_valid", out_valid, 0);
    step(1'b1, 4'b1010);
    check("gate_gray", gray, 4'b1111);
    check("gate_valid", out_valid, 1);
    step(1'b0, 4'b0000);
    check("gate_pulse_end", out_valid, 0);
    check("gate_hold_1111", gray, 4'b1111);
    step(1'b1, 4'd5);
    check("mid_gray5", gray, 4'b0111);
    step(1'b1, 4'd6);
    check("mid_gray6", gray, 4'b0101);
    binary = 4'd7;
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_gray", gray, 0);
    check("async_reset_valid", out_valid, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'd7);
      check("post_reset_gray", gray, 0);
      check("post_reset_valid", out_valid, 0);
    end
`ifdef GRAY_CHECK_EN
    for (int i = 0; i < 16; i++) begin
      step(1'b1, W'(i));
      check("chk_bin", bin_chk, i);
      check("chk_err_clean", chk_err, 0);
    end
    step(1'b1, 4'd3);
    forcing = 1'b1;
    force dut.gray_q = 4'b0011;
    step(1'b0, 4'd0);
    check("chk_err_set", chk_err, 1);
    release dut.gray_q;
    step(1'b0, 4'd0);
    step(1'b1, 4'd9);
    check("chk_err_sticky", chk_err, 1);
    #2 rst_n = 1'b0;
    #1 check("chk_err_reset", chk_err, 0);
    forcing = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b0, 4'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
